uart_word_responder: RTL and testbench
======================================

# uart_word_responder

Responder end of the 16-bit UART word link. It sits between the `UART` client interface and the rest of the design. Each received word is drained through the `UART` request handshake and queued in a small FIFO. A reply word is then transmitted back: an echo for a good word, or a NAK word for a parity-failed word. This gives the FPGA a deterministic peer for any initiator that sends words and expects a reply per word.

## Interface
Parameters:
- `DATA_WIDTH`, 16: word width; matches the `UART` `DATA_WIDTH`.
- `FIFO_DEPTH`, 4: reply FIFO entries; must be a power of two, ≥2.
- `NAK_WORD`, `16'hFFFF` (`DATA_WIDTH` bits): reply sent for a parity-failed word.

Ports:
- `clk` in, 1: the single clock.
- `rst` in, 1: asynchronous, active-high reset.
- `pending_data_rx` in, 1: `UART` holds an unread received word.
- `data_out_rx` in, `DATA_WIDTH`: received word; valid in the cycle `req_data` is high.
- `parity_error_rx` in, 1: parity status of that word; valid with `data_out_rx`.
- `req_data` out, 1: one-cycle read strobe to `UART`.
- `tx_ready` in, 1: `UART` transmitter idle (level).
- `data_valid` out, 1: one-cycle transmit strobe to `UART`.
- `data_in_tx` out, `DATA_WIDTH`: word to transmit; valid while `data_valid` is high.
- `fifo_level` out, `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.
- `drop_count` out, 8: replies lost because the FIFO was full; saturates at 255.
- `err_count` out, 8: parity-failed words received; saturates at 255.

## Operation
- **Reset values:** all outputs are 0 and the FIFO is empty. Both FSMs reset to `IDLE`.
- **RX FSM states:** `IDLE` → `ACK` → `GUARD` → `IDLE`.
  - `IDLE`: if `pending_data_rx` = 1, go to `ACK`.
  - `ACK`: `req_data` = 1. Sample `data_out_rx` and `parity_error_rx`, then generate a push.
  - `GUARD`: `req_data` = 0 for one cycle so `UART` can clear `pending_data_rx`. Back-to-back words are therefore read at most once every 3 cycles.
- **Reply word:**
  - Parity good: the reply is `data_out_rx` unchanged.
  - Parity failed: `err_count` increments. The reply is `NAK_WORD`; see Configuration.
- **Push when full:** if the FIFO is full and no pop occurs in the same cycle, the reply is discarded and `drop_count` increments.
  - A push and a pop in the same cycle are both accepted and `fifo_level` is unchanged. This applies even when the FIFO is full.
- **TX FSM states:** `IDLE` → `SEND` → `WAIT_BUSY` → `WAIT_DONE` → `IDLE`.
  - `IDLE`: if the FIFO is non-empty and `tx_ready` = 1, pop the head into the `data_in_tx` register and go to `SEND`.
  - `SEND`: `data_valid` = 1 for exactly one cycle.
  - `WAIT_BUSY`: wait for `tx_ready` = 0.
  - `WAIT_DONE`: wait for `tx_ready` = 1, then go to `IDLE`.
  - `data_in_tx` holds its value until the next pop.
- **Ordering:** FIFO order is preserved. Replies leave in the same order the words arrived.
- **Counters:** increments saturate at 255 with no wrap. Both counters clear only on `rst`.
- **Reset mid-operation:** an in-flight RX read or TX strobe is abandoned and queued replies are lost. A `UART` frame already started continues on the line unaffected.

## Timing
- Cycle 0 is the edge where `pending_data_rx` = 1 is sampled in `IDLE`. Then:
  - Cycle 1: `req_data` is high.
  - Edge ending cycle 1: the push happens; `fifo_level` updates in cycle 2.
  - Cycle 3: `data_valid` is high, provided the TX FSM is in `IDLE` and `tx_ready` = 1 at the edge ending cycle 2.
- End-to-end latency with an empty FIFO and an idle transmitter is 3 cycles, from sampled `pending_data_rx` to `data_valid`.
- `req_data` and `data_valid` are registered. Both are never high for 2 consecutive cycles.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Full and empty are distinguished by an extra pointer bit.

## Configuration
- `UART_RESPONDER_NAK_EN` defined: each parity-failed word pushes `NAK_WORD` into the FIFO.
- `UART_RESPONDER_NAK_EN` not defined: parity-failed words are discarded with no push and no reply. They are still counted in `err_count`.

## Test plan
- **Single echo:** reset, `tx_ready` = 1, present `16'hA5C0` with `pending_data_rx` asserted until `req_data`. Required: `req_data` 1 cycle later, `data_valid` 3 cycles after the sampled `pending_data_rx`, `data_in_tx` = `16'hA5C0`.
- **NAK path:** word `16'h1234` with `parity_error_rx` = 1.
  - With the macro: reply `16'hFFFF` and `err_count` = 1.
  - Without the macro: no `data_valid` and `err_count` = 1.
- **Overflow:** hold `tx_ready` = 0 and receive 6 words with `FIFO_DEPTH` = 4. Required: `fifo_level` = 4 and `drop_count` = 2. Then release `tx_ready` to pulse low then high per frame; the first 4 words are replied in order.
- **Handshake pacing:** after `data_valid`, keep `tx_ready` = 1 for 5 cycles before dropping it. Required: no second `data_valid` until `tx_ready` has gone 0 and then back to 1.
- **Reset mid-operation:** assert `rst` in the cycle `data_valid` is high with 2 entries queued. Required: all outputs are 0 immediately, and no `data_valid` occurs after release until a new word arrives.
- **Counter saturation:** 300 parity-failed words. Required: `err_count` holds at 255.

Source files
------------

// File: rtl/uart_word_responder.sv
// uart_word_responder: drains received UART words into a reply FIFO and transmits one reply per word.
// Build option UART_RESPONDER_NAK_EN: parity-failed words queue NAK_WORD instead of being discarded.
module uart_word_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] NAK_WORD = 16'hFFFF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pending_data_rx,
  input  logic [DATA_WIDTH-1:0]         data_out_rx,
  input  logic                          parity_error_rx,
  output logic                          req_data,
  input  logic                          tx_ready,
  output logic                          data_valid,
  output logic [DATA_WIDTH-1:0]         data_in_tx,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_count,
  output logic [7:0]                    err_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_GUARD} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_t;
  rx_state_t rx_state_q, rx_state_d;
  tx_state_t tx_state_q, tx_state_d;
  logic req_data_q, req_data_d;
  logic data_valid_q, data_valid_d;
  logic [DATA_WIDTH-1:0] data_in_tx_q, data_in_tx_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0] drop_count_q, drop_count_d, err_count_q, err_count_d;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic empty, full, pop, sampling, push_req, push, drop;
  logic [DATA_WIDTH-1:0] push_word;
  always_comb begin
    empty = wr_ptr_q == rd_ptr_q;
    full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop = (tx_state_q == TX_IDLE) && !empty && tx_ready;
    sampling = rx_state_q == RX_ACK;
`ifdef UART_RESPONDER_NAK_EN
    push_req = sampling;
`else
    push_req = sampling && !parity_error_rx;
`endif
    push_word = parity_error_rx ? NAK_WORD : data_out_rx;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    push = push_req && (!full || pop);
    drop = push_req && full && !pop;
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:  rx_state_d = pending_data_rx ? RX_ACK : RX_IDLE;
      RX_ACK:   rx_state_d = RX_GUARD;
      default:  rx_state_d = RX_IDLE;
    endcase
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE:      tx_state_d = pop ? TX_SEND : TX_IDLE;
      TX_SEND:      tx_state_d = TX_WAIT_BUSY;
      TX_WAIT_BUSY: tx_state_d = tx_ready ? TX_WAIT_BUSY : TX_WAIT_DONE;
      default:      tx_state_d = tx_ready ? TX_IDLE : TX_WAIT_DONE;
    endcase
    req_data_d = rx_state_d == RX_ACK;
    data_valid_d = tx_state_d == TX_SEND;
    data_in_tx_d = pop ? mem[rd_ptr_q[AW-1:0]] : data_in_tx_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    drop_count_d = (drop && drop_count_q != 8'hFF) ? drop_count_q + 8'd1 : drop_count_q;
    err_count_d = (sampling && parity_error_rx && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      tx_state_q <= TX_IDLE;
      req_data_q <= 1'b0;
      data_valid_q <= 1'b0;
      data_in_tx_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_count_q <= '0;
      err_count_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      req_data_q <= req_data_d;
      data_valid_q <= data_valid_d;
      data_in_tx_q <= data_in_tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      drop_count_q <= drop_count_d;
      err_count_q <= err_count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= push_word;
  end
  assign req_data = req_data_q;
  assign data_valid = data_valid_q;
  assign data_in_tx = data_in_tx_q;
  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign drop_count = drop_count_q;
  assign err_count = err_count_q;
endmodule

// File: tb/tb_uart_word_responder.sv
// tb_uart_word_responder: directed stimulus with a reply scoreboard checked by an independent monitor.
module tb_uart_word_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pending_data_rx = 1'b0;
  logic [15:0] data_out_rx = '0;
  logic parity_error_rx = 1'b0;
  logic req_data, data_valid;
  logic [15:0] data_in_tx;
  logic [2:0] fifo_level;
  logic [7:0] drop_count, err_count;
  logic tx_ready, tx_man = 1'b1, tx_auto = 1'b1, auto_tx = 1'b0;
  int hold_hi = 0;
  bit mon_en = 1'b1;
  int vectors = 0;
  int errors = 0;
  logic [15:0] exp_q [$];
  int pace = 0;
  logic req_prev = 1'b0, dv_prev = 1'b0;

  assign tx_ready = auto_tx ? tx_auto : tx_man;

  uart_word_responder dut (
    .clk(clk), .rst(rst), .pending_data_rx(pending_data_rx), .data_out_rx(data_out_rx),
    .parity_error_rx(parity_error_rx), .req_data(req_data), .tx_ready(tx_ready),
    .data_valid(data_valid), .data_in_tx(data_in_tx), .fifo_level(fifo_level),
    .drop_count(drop_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // transmitter model: after each strobe stay ready hold_hi cycles, then busy for 3 cycles
  initial forever begin
    @(negedge clk);
    if (data_valid) begin
      repeat (hold_hi) @(posedge clk);
      #1 tx_auto = 1'b0;
      repeat (3) @(posedge clk);
      #1 tx_auto = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      pace = 0;
      req_prev = 1'b0;
      dv_prev = 1'b0;
    end else begin
      if (req_data && req_prev) begin
        vectors++; errors++;
        $display("FAIL req_back_to_back: req_data high 2 cycles, required single cycle");
      end
      if (data_valid && dv_prev) begin
        vectors++; errors++;
        $display("FAIL dv_back_to_back: data_valid high 2 cycles, required single cycle");
      end
      if (data_valid && mon_en) begin
        vectors++;
        if (pace != 0) begin
          errors++;
          $display("FAIL tx_pacing: data_valid with pacing state %0d, required tx_ready low then high first", pace);
        end
        if (exp_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL unexpected_tx: data_in_tx=%0h, required no reply", data_in_tx);
        end else begin
          logic [15:0] w;
          w = exp_q.pop_front();
          chk("tx_word", {16'h0, data_in_tx}, {16'h0, w});
        end
      end
      if (data_valid) pace = 1;
      else if (pace == 1 && !tx_ready) pace = 2;
      else if (pace == 2 && tx_ready) pace = 0;
      req_prev = req_data;
      dv_prev = data_valid;
    end
  end

  task automatic send_word(input logic [15:0] w, input logic pe, input bit kept);
    int n;
    @(posedge clk);
    #1 pending_data_rx = 1'b1; data_out_rx = w; parity_error_rx = pe;
`ifdef UART_RESPONDER_NAK_EN
    if (kept) exp_q.push_back(pe ? 16'hFFFF : w);
`else
    if (kept && !pe) exp_q.push_back(w);
`endif
    n = 0;
    do begin @(negedge clk); n++; end while (!req_data && n < 20);
    if (!req_data) begin
      vectors++; errors++;
      $display("FAIL req_timeout: req_data 0 after 20 cycles, required 1");
    end
    @(posedge clk);
    #1 pending_data_rx = 1'b0; parity_error_rx = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, {31'h0, req_data}, 0);
    chk({tag, "_dv"}, {31'h0, data_valid}, 0);
    chk({tag, "_data"}, {16'h0, data_in_tx}, 0);
    chk({tag, "_level"}, {29'h0, fifo_level}, 0);
    chk({tag, "_drop"}, {24'h0, drop_count}, 0);
    chk({tag, "_err"}, {24'h0, err_count}, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // single echo with cycle-accurate latency
    @(posedge clk);
    #1 pending_data_rx = 1'b1; data_out_rx = 16'hA5C0; parity_error_rx = 1'b0;
    exp_q.push_back(16'hA5C0);
    @(negedge clk); chk("req_cycle0", {31'h0, req_data}, 0);
    @(negedge clk); chk("req_cycle1", {31'h0, req_data}, 1);
    @(posedge clk); #1 pending_data_rx = 1'b0;
    @(negedge clk);
    chk("level_cycle2", {29'h0, fifo_level}, 1);
    chk("dv_cycle2", {31'h0, data_valid}, 0);
    @(negedge clk);
    chk("dv_cycle3", {31'h0, data_valid}, 1);
    chk("data_cycle3", {16'h0, data_in_tx}, 32'hA5C0);
    chk("level_cycle3", {29'h0, fifo_level}, 0);
    repeat (3) @(negedge clk);
    chk("data_hold", {16'h0, data_in_tx}, 32'hA5C0);
    @(posedge clk); #1 tx_man = 1'b0;
    @(posedge clk); #1 tx_man = 1'b1;
    repeat (6) @(posedge clk);
    #1 auto_tx = 1'b1;

    // parity-failed word, then a good word
    send_word(16'h1234, 1'b1, 1'b1);
    @(negedge clk); chk("err_after_nak", {24'h0, err_count}, 1);
    send_word(16'h0F0F, 1'b0, 1'b1);
    repeat (20) @(posedge clk);

    // overflow: six words into a 4-deep FIFO with the transmitter held busy
    #1 auto_tx = 1'b0; tx_man = 1'b0;
    send_word(16'h1111, 1'b0, 1'b1);
    send_word(16'h2222, 1'b0, 1'b1);
    send_word(16'h3333, 1'b0, 1'b1);
    send_word(16'h4444, 1'b0, 1'b1);
    send_word(16'h5555, 1'b0, 1'b0);
    send_word(16'h6666, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovf_level", {29'h0, fifo_level}, 4);
    chk("ovf_drop", {24'h0, drop_count}, 2);
    #2 auto_tx = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("ovf_drained", {29'h0, fifo_level}, 0);
    chk("ovf_sb_empty", exp_q.size(), 0);

    // push and pop on the same edge while full
    @(posedge clk); #1 auto_tx = 1'b0; tx_man = 1'b0;
    send_word(16'hA001, 1'b0, 1'b1);
    send_word(16'hA002, 1'b0, 1'b1);
    send_word(16'hA003, 1'b0, 1'b1);
    send_word(16'hA004, 1'b0, 1'b1);
    @(posedge clk);
    #1 pending_data_rx = 1'b1; data_out_rx = 16'hA005;
    exp_q.push_back(16'hA005);
    n = 0;
    do begin @(negedge clk); n++; end while (!req_data && n < 20);
    chk("full_req", {31'h0, req_data}, 1);
    #1 tx_man = 1'b1;
    @(posedge clk); #1 pending_data_rx = 1'b0;
    @(negedge clk);
    chk("full_pushpop_level", {29'h0, fifo_level}, 4);
    chk("full_pushpop_drop", {24'h0, drop_count}, 2);
    #2 auto_tx = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("full_sb_empty", exp_q.size(), 0);

    // pacing: transmitter stays ready 5 cycles after each strobe
    hold_hi = 5;
    send_word(16'hBEEF, 1'b0, 1'b1);
    send_word(16'hCAFE, 1'b0, 1'b1);
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("pace_sb_empty", exp_q.size(), 0);
    hold_hi = 0;
    repeat (10) @(posedge clk);

    // reset while a strobe is out and two replies remain queued
    #1 auto_tx = 1'b0; tx_man = 1'b0;
    send_word(16'hB001, 1'b0, 1'b1);
    send_word(16'hB002, 1'b0, 1'b1);
    send_word(16'hB003, 1'b0, 1'b1);
    @(posedge clk); #1 tx_man = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!data_valid && n < 20);
    chk("rst_dv_seen", {31'h0, data_valid}, 1);
    chk("rst_level_before", {29'h0, fifo_level}, 2);
    #1 rst = 1'b1;
    #1 chk_zero("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("post_rst_level", {29'h0, fifo_level}, 0);
    #2 auto_tx = 1'b1;
    repeat (5) @(posedge clk);
    send_word(16'hC0DE, 1'b0, 1'b1);
    repeat (20) @(posedge clk);

    // error counter saturation
`ifdef UART_RESPONDER_NAK_EN
    mon_en = 1'b0;
`endif
    for (int i = 0; i < 254; i++) send_word(i[15:0], 1'b1, 1'b0);
    @(negedge clk); chk("err_254", {24'h0, err_count}, 254);
    for (int i = 0; i < 46; i++) send_word(i[15:0], 1'b1, 1'b0);
    @(negedge clk); chk("err_sat", {24'h0, err_count}, 255);
`ifndef UART_RESPONDER_NAK_EN
    chk("sat_drop", {24'h0, drop_count}, 0);
`endif
    repeat (100) @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    chk("final_sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
